reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//  Register file that answers the decode stage's read requests: regaRd/regaAddr and
//  regbRd/regbAddr in, regaData_o/regbData_o back to the decoder's regaData_i/regbData_i.
//  It also accepts the regcWr/regcAddr write-back from the execute path.
//  Writes pass through a one-entry write-back staging register before they reach the array.
//  Full bypassing makes every accepted write visible to reads in the same cycle it is presented.
// PARAMETERS
//  DATA_W    32  register data width (REG_LENGTH)
//  ADDR_W    5   register address width (REG_ADDR_LEN)
//  NUM_REGS  32  number of architectural registers; r0 is hardwired to zero
//  CNT_W     16  width of the committed-write counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       reset, synchronous, active-high
//  regaRd      in   1       read enable, port A
//  regaAddr    in   ADDR_W  read address, port A
//  regbRd      in   1       read enable, port B
//  regbAddr    in   ADDR_W  read address, port B
//  regaData_o  out  DATA_W  read data, port A (combinational)
//  regbData_o  out  DATA_W  read data, port B (combinational)
//  regcWr      in   1       write request
//  regcAddr    in   ADDR_W  write address
//  regcData    in   DATA_W  write data
//  stg_valid   out  1       staging register holds an uncommitted write
//  wr_cnt      out  CNT_W   number of writes committed to the array since reset
// BEHAVIOUR
//  Write acceptance
//   - A write is accepted when regcWr=1, regcAddr!=0 and regcAddr<NUM_REGS.
//   - Any other write is dropped: it is not staged, not counted and not bypassed.
//  Pipeline
//   - Posedge T with an accepted write: stage <= {1, regcAddr, regcData}.
//   - Posedge T with no accepted write: stg_valid <= 0.
//   - Posedge T+1: if the stage is valid, the array entry is written and wr_cnt increments.
//   - This commit happens regardless of what is presented at T+1.
//   - Stage-to-array latency is 1 cycle; there is no backpressure and the stage never stalls.
//  Read path (combinational, evaluated per port, first match wins)
//   1. Rd=0, rst=1, addr=0 or addr>=NUM_REGS -> output 0.
//   2. Accepted incoming write with regcAddr==addr -> regcData (write-first).
//   3. stg_valid=1 and stage address==addr -> stage data.
//   4. Otherwise -> array entry.
//   - Ports A and B are independent; both may hit the same bypass source in one cycle.
//  Reset
//   - Posedge with rst=1 clears every array entry, the stage, stg_valid and wr_cnt to 0.
//   - A staged write pending at reset is discarded and not counted.
//   - A write presented during the reset cycle is ignored.
//   - Outputs read 0 while rst=1 and reset state holds from the first posedge after rst falls.
//  Boundaries
//   - Back-to-back writes to the same address: the newer value is bypassed.
//   - The older value commits first, then is overwritten one cycle later.
//   - wr_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//   - The array has no other write path; there are no X outputs after reset.
// TESTING
//  T1 reset: write r5 during rst=1, then read A=r5, B=r31 after reset
//     -> both 0, wr_cnt=0, stg_valid=0.
//  T2 bypass: cycle0 regcWr r3<=0x1234_5678 with regaRd=1, regaAddr=3
//     -> regaData_o=0x12345678 in cycle0, stage-hit in cycle1, array in cycle2.
//  T3 r0 and disabled reads: write r0<=0xFFFF_FFFF, then read A=r0, and read r3 with regbRd=0
//     -> 0 and 0; wr_cnt unchanged; stg_valid=0.
//  T4 same-address chain: r7<=1, r7<=2, r7<=3 on consecutive cycles, reading r7 on port B
//     -> 1, 2, 3 each cycle; final array r7=3; wr_cnt=3.
//  T5 reset mid-flight: write r9<=0xAA, assert rst in the next cycle
//     -> r9 reads 0 after reset; wr_cnt=0.
//  T6 counter wrap: 65536 accepted writes from reset -> wr_cnt=0x0000; 65535 writes -> 0xFFFF.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read, one-write register file with a write-back staging register and full bypass
// r0 reads zero; accepted writes are visible to reads in the cycle they are presented.
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regaRd,
  input  logic [ADDR_W-1:0] regaAddr,
  input  logic              regbRd,
  input  logic [ADDR_W-1:0] regbAddr,
  output logic [DATA_W-1:0] regaData_o,
  output logic [DATA_W-1:0] regbData_o,
  input  logic              regcWr,
  input  logic [ADDR_W-1:0] regcAddr,
  input  logic [DATA_W-1:0] regcData,
  output logic              stg_valid,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [ADDR_W-1:0] stg_addr;
  logic [DATA_W-1:0] stg_data;
  logic              acc;

  // r0 and addresses beyond the implemented registers are never stored or read
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({{(32-ADDR_W){1'b0}}, a} < NUM_REGS_U);
  endfunction

  assign acc = regcWr && addr_ok(regcAddr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
      wr_cnt    <= '0;
    end else begin
      if (stg_valid) begin
        mem[stg_addr] <= stg_data;
        wr_cnt        <= wr_cnt + CNT_W'(1);
      end
      stg_valid <= acc;
      if (acc) begin
        stg_addr <= regcAddr;
        stg_data <= regcData;
      end
    end
  end

  // Priority: disabled/reset/invalid, incoming write, staged write, array
  function automatic logic [DATA_W-1:0] read_port(input logic en, input logic [ADDR_W-1:0] addr);
    if (!en || rst || !addr_ok(addr))
      return '0;
    else if (acc && regcAddr == addr)
      return regcData;
    else if (stg_valid && stg_addr == addr)
      return stg_data;
    else
      return mem[addr];
  endfunction

  always_comb begin
    regaData_o = read_port(regaRd, regaAddr);
  end

  always_comb begin
    regbData_o = read_port(regbRd, regbAddr);
  end

endmodule
